// File: rtl/tl_traffic_sensor_pkg.sv
// Shared traffic-light definitions: light codes seen by controller and sensor,
// plus the sizing of the per-lane departure timer.
package tl_traffic_sensor_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      LEFT   = 2'b10,
      RED    = 2'b11
   } light_t;

   // Wide enough for timer values 0..14 (DEP_CYCLES up to 15).
   localparam int TMR_W = 4;

endpackage

// File: rtl/tl_lane_queue.sv
// One lane: saturating vehicle queue counter, departure timer and sticky
// overflow flag.
module tl_lane_queue
   import tl_traffic_sensor_pkg::*;
#(
   parameter int DEP_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serve,
   input  logic             arr,
   output logic [CNT_W-1:0] cnt,
   output logic             occ,
   output logic             ovf
);

   logic [TMR_W-1:0] tmr;
   logic [TMR_W-1:0] tmr_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic             qual;
   logic             dep;

   always_comb begin
      qual    = serve && (cnt != '0);
      dep     = qual && (tmr == TMR_W'(DEP_CYCLES - 1));
      tmr_nxt = '0;
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (qual && !dep)
         tmr_nxt = tmr + 1'b1;
      // A same-edge departure frees a slot, so a full queue only drops when nothing leaves.
      if (arr && !dep) begin
         if (cnt == '1)
            ovf_nxt = 1'b1;
         else
            cnt_nxt = cnt + 1'b1;
      end else if (dep && !arr) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         tmr <= tmr_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

   assign occ = (cnt != '0);

endmodule

// File: rtl/tl_traffic_sensor.sv
// Traffic sensor: decodes which lanes the lights serve, tracks four lane
// queues and flags conflicting light combinations.
module tl_traffic_sensor
   import tl_traffic_sensor_pkg::*;
#(
   parameter int DEP_CYCLES = 2,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       La,
   input  logic [1:0]       Lb,
   input  logic             arr_a,
   input  logic             arr_al,
   input  logic             arr_b,
   input  logic             arr_bl,
   output logic             Ta,
   output logic             Tal,
   output logic             Tb,
   output logic             Tbl,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_al,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_bl,
   output logic [3:0]       ovf,
   output logic             conflict
);

   logic serve_a, serve_al, serve_b, serve_bl;
   logic ovf_a, ovf_al, ovf_b, ovf_bl;

   always_comb begin
      serve_a  = (La == GREEN);
      serve_al = (La == LEFT);
      serve_b  = (Lb == GREEN);
      serve_bl = (Lb == LEFT);
   end

   tl_lane_queue #(.DEP_CYCLES(DEP_CYCLES), .CNT_W(CNT_W)) u_lane_a (
      .clk(clk), .reset(reset), .serve(serve_a), .arr(arr_a),
      .cnt(cnt_a), .occ(Ta), .ovf(ovf_a)
   );

   tl_lane_queue #(.DEP_CYCLES(DEP_CYCLES), .CNT_W(CNT_W)) u_lane_al (
      .clk(clk), .reset(reset), .serve(serve_al), .arr(arr_al),
      .cnt(cnt_al), .occ(Tal), .ovf(ovf_al)
   );

   tl_lane_queue #(.DEP_CYCLES(DEP_CYCLES), .CNT_W(CNT_W)) u_lane_b (
      .clk(clk), .reset(reset), .serve(serve_b), .arr(arr_b),
      .cnt(cnt_b), .occ(Tb), .ovf(ovf_b)
   );

   tl_lane_queue #(.DEP_CYCLES(DEP_CYCLES), .CNT_W(CNT_W)) u_lane_bl (
      .clk(clk), .reset(reset), .serve(serve_bl), .arr(arr_bl),
      .cnt(cnt_bl), .occ(Tbl), .ovf(ovf_bl)
   );

   assign ovf = {ovf_bl, ovf_b, ovf_al, ovf_a};

   // Both streets showing anything but red is a controller fault; latch it until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         conflict <= 1'b0;
      else if ((La != RED) && (Lb != RED))
         conflict <= 1'b1;
   end

endmodule

// File: tb/tb_tl_traffic_sensor.sv
// Directed self-checking bench for tl_traffic_sensor with default parameters
// (DEP_CYCLES=2, CNT_W=4).
module tb_tl_traffic_sensor;

   localparam logic [1:0] C_GREEN  = 2'b00;
   localparam logic [1:0] C_YELLOW = 2'b01;
   localparam logic [1:0] C_LEFT   = 2'b10;
   localparam logic [1:0] C_RED    = 2'b11;

   logic       clk;
   logic       reset;
   logic [1:0] La, Lb;
   logic       arr_a, arr_al, arr_b, arr_bl;
   logic       Ta, Tal, Tb, Tbl;
   logic [3:0] cnt_a, cnt_al, cnt_b, cnt_bl;
   logic [3:0] ovf;
   logic       conflict;

   int checks = 0;
   int errors = 0;

   tl_traffic_sensor #(.DEP_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .La(La), .Lb(Lb),
      .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
      .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
      .cnt_a(cnt_a), .cnt_al(cnt_al), .cnt_b(cnt_b), .cnt_bl(cnt_bl),
      .ovf(ovf), .conflict(conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; La = C_RED; Lb = C_RED;
      arr_a = 1'b1; arr_al = 1'b0; arr_b = 1'b0; arr_bl = 1'b0;
      tick(); tick(); tick();
      checks++;
      if ({cnt_a, cnt_al, cnt_b, cnt_bl} !== 16'h0) begin
         errors++; $display("FAIL reset_counts got %h want 0000", {cnt_a, cnt_al, cnt_b, cnt_bl});
      end
      checks++;
      if ({Ta, Tal, Tb, Tbl, ovf, conflict} !== 9'b0) begin
         errors++; $display("FAIL reset_flags got %b want 000000000", {Ta, Tal, Tb, Tbl, ovf, conflict});
      end
      arr_a = 1'b0;
      reset = 1'b0;
      arr_a = 1'b1; tick(); arr_a = 1'b0; tick();
      arr_a = 1'b1; tick(); arr_a = 1'b0;
      checks++;
      if (cnt_a !== 4'd2 || Ta !== 1'b1) begin
         errors++; $display("FAIL arrive_a got cnt=%0d T=%b want cnt=2 T=1", cnt_a, Ta);
      end
   endtask

   task automatic test_depart_a();
      logic [3:0] exp_cnt [4];
      exp_cnt[0] = 4'd2; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd1; exp_cnt[3] = 4'd0;
      La = C_GREEN;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (cnt_a !== exp_cnt[i]) begin
            errors++; $display("FAIL depart_a_edge%0d got %0d want %0d", i + 1, cnt_a, exp_cnt[i]);
         end
      end
      checks++;
      if (Ta !== 1'b0) begin
         errors++; $display("FAIL depart_a_empty_T got %b want 0", Ta);
      end
      // Idle green with an empty queue must leave the timer at zero.
      tick(); tick();
      La = C_RED;
      arr_a = 1'b1; tick(); arr_a = 1'b0;
      La = C_GREEN;
      tick();
      checks++;
      if (cnt_a !== 4'd1) begin
         errors++; $display("FAIL timer_idle_zero got %0d want 1", cnt_a);
      end
      tick();
      checks++;
      if (cnt_a !== 4'd0) begin
         errors++; $display("FAIL timer_idle_depart got %0d want 0", cnt_a);
      end
      La = C_RED;
   endtask

   task automatic test_left_abort();
      arr_al = 1'b1; tick(); arr_al = 1'b0;
      La = C_LEFT; tick();
      La = C_YELLOW; tick();
      checks++;
      if (cnt_al !== 4'd1 || Tal !== 1'b1) begin
         errors++; $display("FAIL left_abort got cnt=%0d T=%b want cnt=1 T=1", cnt_al, Tal);
      end
      La = C_LEFT; tick();
      checks++;
      if (cnt_al !== 4'd1) begin
         errors++; $display("FAIL left_timer_cleared got %0d want 1", cnt_al);
      end
      tick();
      checks++;
      if (cnt_al !== 4'd0 || Tal !== 1'b0) begin
         errors++; $display("FAIL left_depart got cnt=%0d T=%b want cnt=0 T=0", cnt_al, Tal);
      end
      La = C_RED;
   endtask

   task automatic test_overflow_b();
      arr_b = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      arr_b = 1'b0;
      checks++;
      if (cnt_b !== 4'd15 || ovf !== 4'b0000) begin
         errors++; $display("FAIL fill_b got cnt=%0d ovf=%b want cnt=15 ovf=0000", cnt_b, ovf);
      end
      arr_b = 1'b1; tick(); arr_b = 1'b0;
      checks++;
      if (cnt_b !== 4'd15 || ovf !== 4'b0100) begin
         errors++; $display("FAIL ovf_b got cnt=%0d ovf=%b want cnt=15 ovf=0100", cnt_b, ovf);
      end
      Lb = C_GREEN; tick();
      arr_b = 1'b1; tick(); arr_b = 1'b0;
      Lb = C_RED;
      checks++;
      if (cnt_b !== 4'd15 || ovf !== 4'b0100) begin
         errors++; $display("FAIL full_arr_dep got cnt=%0d ovf=%b want cnt=15 ovf=0100", cnt_b, ovf);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_cnt [5];
      exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd2; exp_cnt[3] = 4'd3; exp_cnt[4] = 4'd2;
      La = C_GREEN;
      arr_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) arr_a = 1'b0;
         tick();
         checks++;
         if (cnt_a !== exp_cnt[i]) begin
            errors++; $display("FAIL b2b_edge%0d got %0d want %0d", i + 1, cnt_a, exp_cnt[i]);
         end
      end
      for (int i = 0; i < 4; i++) tick();
      La = C_RED;
      checks++;
      if (cnt_a !== 4'd0) begin
         errors++; $display("FAIL b2b_drain got %0d want 0", cnt_a);
      end
   endtask

   task automatic test_conflict();
      checks++;
      if (conflict !== 1'b0) begin
         errors++; $display("FAIL conflict_idle got %b want 0", conflict);
      end
      La = C_GREEN; Lb = C_LEFT; tick();
      La = C_RED; Lb = C_RED;
      checks++;
      if (conflict !== 1'b1) begin
         errors++; $display("FAIL conflict_set got %b want 1", conflict);
      end
      tick(); tick(); tick();
      checks++;
      if (conflict !== 1'b1) begin
         errors++; $display("FAIL conflict_sticky got %b want 1", conflict);
      end
   endtask

   task automatic test_reset_mid();
      arr_bl = 1'b1; tick(); tick(); tick(); arr_bl = 1'b0;
      checks++;
      if (cnt_bl !== 4'd3) begin
         errors++; $display("FAIL fill_bl got %0d want 3", cnt_bl);
      end
      Lb = C_LEFT; tick();
      reset = 1'b1;
      #1;
      checks++;
      if ({cnt_a, cnt_al, cnt_b, cnt_bl} !== 16'h0 || ovf !== 4'b0 || conflict !== 1'b0) begin
         errors++; $display("FAIL async_reset got cnts=%h ovf=%b conflict=%b want 0000 0000 0",
                            {cnt_a, cnt_al, cnt_b, cnt_bl}, ovf, conflict);
      end
      checks++;
      if ({Ta, Tal, Tb, Tbl} !== 4'b0) begin
         errors++; $display("FAIL async_reset_T got %b want 0000", {Ta, Tal, Tb, Tbl});
      end
      tick();
      Lb = C_RED;
      reset = 1'b0;
      arr_bl = 1'b1; tick(); arr_bl = 1'b0;
      checks++;
      if (cnt_bl !== 4'd1 || Tbl !== 1'b1) begin
         errors++; $display("FAIL post_reset_arr got cnt=%0d T=%b want cnt=1 T=1", cnt_bl, Tbl);
      end
      Lb = C_LEFT; tick();
      checks++;
      if (cnt_bl !== 4'd1) begin
         errors++; $display("FAIL post_reset_partial got %0d want 1", cnt_bl);
      end
      tick();
      Lb = C_RED;
      checks++;
      if (cnt_bl !== 4'd0 || Tbl !== 1'b0) begin
         errors++; $display("FAIL post_reset_depart got cnt=%0d T=%b want cnt=0 T=0", cnt_bl, Tbl);
      end
   endtask

   initial begin
      test_reset();
      test_depart_a();
      test_left_abort();
      test_overflow_b();
      test_back_to_back();
      test_conflict();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_traffic_sensor.md
TL_TRAFFIC_SENSOR -- requirements
Module: tl_traffic_sensor

Interface
REQ-001 The block SHALL have parameter DEP_CYCLES, default 2, meaning qualifying clock edges per vehicle departure; legal range 1..15.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the width of each lane queue counter.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports La, Lb  input  2 each  street A and street B light codes driven by the controller.
REQ-006 The block SHALL have ports arr_a, arr_al, arr_b, arr_bl  input  1 each  one-cycle vehicle arrival pulses for A straight, A left, B straight and B left.
REQ-007 The block SHALL have ports Ta, Tal, Tb, Tbl  output  1 each  lane-occupied sensor signals to the controller.
REQ-008 The block SHALL have ports cnt_a, cnt_al, cnt_b, cnt_bl  output  CNT_W each  current queue depth per lane.
REQ-009 The block SHALL have port ovf  output  4  sticky per-lane overflow flags, order {bl,b,al,a}.
REQ-010 The block SHALL have port conflict  output  1  sticky flag for conflicting lights.

Function
REQ-011 Light codes SHALL be 00 GREEN (straight), 01 YELLOW, 10 LEFT (left-turn arrow), 11 RED.
REQ-012 Lane serving SHALL be: A straight when La==GREEN, A left when La==LEFT, B straight when Lb==GREEN, B left when Lb==LEFT; YELLOW and RED serve no lane.
REQ-013 Each lane SHALL hold a queue counter and a departure timer (0..DEP_CYCLES-1).
REQ-014 On each edge where the lane is served and its count>0, the timer SHALL increment; at timer==DEP_CYCLES-1 a departure SHALL occur and the timer SHALL return to 0.
REQ-015 The timer SHALL clear to 0 on any edge where the lane is not served or its count==0.
REQ-016 With DEP_CYCLES=1, a departure SHALL occur on every qualifying edge.
REQ-017 An arrival without a departure SHALL increment the count; a departure without an arrival SHALL decrement it; a simultaneous arrival and departure SHALL leave it unchanged.
REQ-018 An arrival at count==2^CNT_W-1 with no same-edge departure SHALL be dropped, the count SHALL hold, and that lane's ovf bit SHALL set.
REQ-019 A departure SHALL never occur at count==0, so the count never wraps below zero.
REQ-020 Each T output SHALL equal (lane count != 0) and SHALL change on the same edge as the count.
REQ-021 The conflict flag SHALL set on any edge where La!=RED and Lb!=RED, and SHALL hold until reset.
REQ-022 Input La/Lb changes SHALL take effect on the next rising edge with no internal synchronisation.

Reset
REQ-023 While reset is high, all counts, timers, T outputs, ovf and conflict SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-departure SHALL discard all partial timer progress.
REQ-025 An arrival pulse coincident with reset release SHALL be ignored; the first counted arrival is on the first edge with reset low.

Structure
REQ-026 The light-code constants (GREEN, YELLOW, LEFT, RED) SHALL live in the shared traffic-light package used by the controller.
REQ-027 The per-lane counter and timer SHALL be one sub-module, tl_lane_queue, instantiated four times; top level does serve decode, conflict check and output packing.

Verification
REQ-028 Reset high, arr_a pulses -> all counts 0, Ta=0; after release, two arr_a pulses with La=RED -> cnt_a=2, Ta=1.
REQ-029 cnt_a=2, DEP_CYCLES=2, La=GREEN held -> cnt_a=1 after the 2nd edge, 0 after the 4th, Ta=0; timer then stays 0.
REQ-030 cnt_al=1, La=LEFT for one edge then YELLOW -> no departure, timer cleared; later La=LEFT for 2 edges -> cnt_al=0.
REQ-031 cnt_b=15, arr_b pulse, Lb=RED -> cnt_b=15, ovf=0100; repeat with a same-edge departure under Lb=GREEN -> cnt_b=15, no additional flag change.
REQ-032 La=GREEN and Lb=LEFT for one edge -> conflict=1, held after both return to RED until reset.
REQ-033 cnt_bl=3, Lb=LEFT, reset pulsed after one qualifying edge -> all counts 0; after release, arr_bl pulse -> cnt_bl=1, departure after 2 further qualifying edges.
